// File: rtl/versat_run_ctrl_pkg.sv
// versat_run_ctrl_pkg
//   Shared definitions for the Versat run sequencer:
//   - word indices of the CPU-visible registers,
//   - bit positions inside CTRL and STATUS,
//   - 3-bit FSM state encodings,
//   - helper that turns the programmed ITER value into an iteration count.
package versat_run_ctrl_pkg;

  // Register map, word index taken from addr[2:0]
  localparam logic [2:0] VRC_CTRL    = 3'd0;
  localparam logic [2:0] VRC_CONST0  = 3'd1;
  localparam logic [2:0] VRC_CONST1  = 3'd2;
  localparam logic [2:0] VRC_DELAY   = 3'd3;
  localparam logic [2:0] VRC_ITER    = 3'd4;
  localparam logic [2:0] VRC_STATUS  = 3'd5;
  localparam logic [2:0] VRC_RESULT  = 3'd6;
  localparam logic [2:0] VRC_TIMEOUT = 3'd7;

  // CTRL bits
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_ABORT_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  // STATUS bits
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_DONE_BIT    = 1;
  localparam int STAT_TIMEOUT_BIT = 2;
  localparam int STAT_ITER_BIT    = 3;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PULSE   = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;

  // A programmed iteration count of zero still runs the datapath once.
  function automatic logic [15:0] vrc_iter_load(input logic [15:0] iter);
    return (iter == 16'd0) ? 16'd1 : iter;
  endfunction

endpackage

// File: rtl/versat_run_ctrl.sv
// versat_run_ctrl
//   Memory-mapped run sequencer for a Versat accelerator instance. The CPU
//   programs two constants, a register delay, an iteration count and a
//   timeout, then writes START. The block pulses `run`, waits for the
//   datapath `done`, captures `currentValue_00` into RESULT and repeats for
//   the requested number of iterations.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   valid/addr/wstrb/wdata -> ready/rdata
//                     CPU slave port; ready and rdata are registered and
//                     appear one cycle after a valid cycle
//   run               one-cycle run pulse to the datapath
//   done              datapath done (AND of unit dones)
//   constant_00/01    datapath constants (CONST0/CONST1)
//   delay0            register-unit delay (DELAY)
//   currentValue_00   datapath result, captured into RESULT
//   irq               level interrupt: (done | timeout) & irq_en
`default_nettype none

`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef DATA_W
`define DATA_W 32
`endif

module versat_run_ctrl
  import versat_run_ctrl_pkg::*;
#(
  parameter int ADDR_W = `ADDR_W,
  parameter int DATA_W = `DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   wdata,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                run,
  input  logic                done,
  output logic [31:0]         constant_00,
  output logic [31:0]         constant_01,
  output logic [31:0]         delay0,
  input  logic [31:0]         currentValue_00,
  output logic                irq
);

  // --------------------------------------------------------------------
  // Register state
  // --------------------------------------------------------------------
  logic [2:0]  state_reg,        state_next;
  logic [15:0] iter_left_reg,    iter_left_next;
  logic [31:0] tcnt_reg,         tcnt_next;
  logic [31:0] result_reg,       result_next;
  logic        done_flag_reg,    done_flag_next;
  logic        timeout_flag_reg, timeout_flag_next;

  logic [31:0] const0_reg;
  logic [31:0] const1_reg;
  logic [31:0] delay_reg;
  logic [15:0] iter_reg;
  logic [31:0] tmo_limit_reg;
  logic        irq_en_reg;

  logic              ready_reg;
  logic [DATA_W-1:0] rdata_reg;

  // --------------------------------------------------------------------
  // Bus decode
  // --------------------------------------------------------------------
  logic [2:0]  widx;
  logic [31:0] wword;
  logic        bus_acc;
  logic        bus_wr;
  logic        bus_rd;
  logic        busy;
  logic        cfg_wr_en;
  logic        start_req;
  logic        abort_req;
  logic [7:0]  wr_sel;
  logic [31:0] rd_word;

  // Only addr[2:0] is decoded; the upper address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^addr[ADDR_W-1:3];

  assign widx  = addr[2:0];
  assign wword = wdata[31:0];

  // A request is taken once: the CPU drops valid during the ready cycle,
  // and masking with ready_reg keeps a late valid from being re-accepted.
  assign bus_acc = valid && !ready_reg;
  assign bus_wr  = bus_acc && (|wstrb);
  assign bus_rd  = bus_acc && !(|wstrb);

  assign busy = (state_reg != ST_IDLE);

  // Per-register write strobes
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_wr_sel
      assign wr_sel[gi] = bus_wr && (widx == 3'(gi));
    end
  endgenerate

  // Configuration writes are acknowledged but dropped while a run is active
  assign cfg_wr_en = !busy;
  assign start_req = wr_sel[VRC_CTRL] && wword[CTRL_START_BIT];
  assign abort_req = wr_sel[VRC_CTRL] && wword[CTRL_ABORT_BIT];

  // Read mux, sampled into rdata_reg at the acknowledge edge
  always_comb begin
    rd_word = 32'd0;
    case (widx)
      VRC_CTRL:    rd_word = {29'd0, irq_en_reg, 2'b00};
      VRC_CONST0:  rd_word = const0_reg;
      VRC_CONST1:  rd_word = const1_reg;
      VRC_DELAY:   rd_word = delay_reg;
      VRC_ITER:    rd_word = {16'd0, iter_reg};
      VRC_STATUS:  rd_word = {28'd0, (iter_left_reg != 16'd0), timeout_flag_reg,
                               done_flag_reg, busy};
      VRC_RESULT:  rd_word = result_reg;
      VRC_TIMEOUT: rd_word = tmo_limit_reg;
      default:     rd_word = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------
  // Run sequencer
  // --------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    iter_left_next    = iter_left_reg;
    tcnt_next         = tcnt_reg;
    result_next       = result_reg;
    done_flag_next    = done_flag_reg;
    timeout_flag_next = timeout_flag_reg;

    // Write-1-to-clear is applied first so a same-cycle set from the FSM
    // below overrides it.
    if (wr_sel[VRC_STATUS]) begin
      if (wword[STAT_DONE_BIT])    done_flag_next    = 1'b0;
      if (wword[STAT_TIMEOUT_BIT]) timeout_flag_next = 1'b0;
    end

    if (busy && abort_req) begin
      // Abort outranks a same-cycle done or timeout; status flags are kept.
      state_next     = ST_IDLE;
      iter_left_next = 16'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_req) begin
            state_next        = ST_PULSE;
            iter_left_next    = vrc_iter_load(iter_reg);
            done_flag_next    = 1'b0;
            timeout_flag_next = 1'b0;
          end
        end
        ST_PULSE: begin
          tcnt_next  = 32'd0;
          state_next = ST_SETTLE;
        end
        ST_SETTLE: begin
          // Unit done only drops the cycle after run, so it is not trusted here.
          state_next = ST_WAIT;
        end
        ST_WAIT: begin
          if (done) begin
            state_next = ST_CAPTURE;
          end else if ((tmo_limit_reg != 32'd0) &&
                       (tcnt_reg == tmo_limit_reg - 32'd1)) begin
            // A timed-out run leaves no iterations pending.
            timeout_flag_next = 1'b1;
            iter_left_next    = 16'd0;
            state_next        = ST_IDLE;
          end else begin
            tcnt_next = tcnt_reg + 32'd1;
          end
        end
        ST_CAPTURE: begin
          result_next    = currentValue_00;
          iter_left_next = iter_left_reg - 16'd1;
          if (iter_left_reg != 16'd1) begin
            state_next = ST_PULSE;
          end else begin
            done_flag_next = 1'b1;
            state_next     = ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      iter_left_reg    <= 16'd0;
      tcnt_reg         <= 32'd0;
      result_reg       <= 32'd0;
      done_flag_reg    <= 1'b0;
      timeout_flag_reg <= 1'b0;
      const0_reg       <= 32'd0;
      const1_reg       <= 32'd0;
      delay_reg        <= 32'd0;
      iter_reg         <= 16'd0;
      tmo_limit_reg    <= 32'd0;
      irq_en_reg       <= 1'b0;
      ready_reg        <= 1'b0;
      rdata_reg        <= '0;
    end else begin
      state_reg        <= state_next;
      iter_left_reg    <= iter_left_next;
      tcnt_reg         <= tcnt_next;
      result_reg       <= result_next;
      done_flag_reg    <= done_flag_next;
      timeout_flag_reg <= timeout_flag_next;

      if (cfg_wr_en && wr_sel[VRC_CONST0])  const0_reg    <= wword;
      if (cfg_wr_en && wr_sel[VRC_CONST1])  const1_reg    <= wword;
      if (cfg_wr_en && wr_sel[VRC_DELAY])   delay_reg     <= wword;
      if (cfg_wr_en && wr_sel[VRC_ITER])    iter_reg      <= wword[15:0];
      if (cfg_wr_en && wr_sel[VRC_TIMEOUT]) tmo_limit_reg <= wword;
      // irq_en holds whatever the last CTRL write put in its bit
      if (wr_sel[VRC_CTRL])                 irq_en_reg    <= wword[CTRL_IRQ_EN_BIT];

      ready_reg <= bus_acc;
      rdata_reg <= bus_rd ? DATA_W'(rd_word) : '0;
    end
  end

  // --------------------------------------------------------------------
  // Outputs; all derive from reset registers so they clear with rst
  // --------------------------------------------------------------------
  assign ready       = ready_reg;
  assign rdata       = rdata_reg;
  assign run         = (state_reg == ST_PULSE);
  assign constant_00 = const0_reg;
  assign constant_01 = const1_reg;
  assign delay0      = delay_reg;
  assign irq         = irq_en_reg && (done_flag_reg || timeout_flag_reg);

endmodule

`default_nettype wire
